// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the memory bus SRAM port.
// Build macro MEMORY_BUS_WRITE_PROTECT_EN turns on write protection of the low ROM region.
package memory_bus_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_MASK_WIDTH = 4;
    localparam int REQ_ADDR_WIDTH = 32;

`ifdef MEMORY_BUS_WRITE_PROTECT_EN
    localparam bit WRITE_PROTECT_EN = 1'b1;
`else
    localparam bit WRITE_PROTECT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WAIT,
        RESPOND
    } state_t;

    typedef struct packed {
        logic [REQ_ADDR_WIDTH-1:0] address;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic [BUS_MASK_WIDTH-1:0] mask;
        logic                      write;
    } request_t;

endpackage

// File: rtl/memory_bus_range_check.sv
// Combinational accept/reject decision for a bus request: out-of-range address, or a
// write into the protected low region when MEMORY_BUS_WRITE_PROTECT_EN is defined.
module memory_bus_range_check
    import memory_bus_pkg::*;
#(
    parameter int RAM_SIZE_WORDS = 2048,
    parameter int ROM_SIZE_WORDS = 256
) (
    input  logic [REQ_ADDR_WIDTH-1:0] address,
    input  logic                      write,
    output logic                      reject
);

    logic out_of_range;
    logic write_protected;

    assign out_of_range    = address >= REQ_ADDR_WIDTH'(RAM_SIZE_WORDS);
    assign write_protected = WRITE_PROTECT_EN && write
                             && (address < REQ_ADDR_WIDTH'(ROM_SIZE_WORDS));
    assign reject          = out_of_range || write_protected;

endmodule

// File: rtl/memory_bus_sram_port.sv
// Memory bus slave driving an external 1-cycle-latency block RAM, with wait states and
// error responses. Optional write protection via MEMORY_BUS_WRITE_PROTECT_EN.
module memory_bus_sram_port
    import memory_bus_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 15,
    parameter int RAM_SIZE_WORDS = 2048,
    parameter int WAIT_STATES    = 0,
    parameter int ROM_SIZE_WORDS = 256
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              busValid,
    input  logic [ADDRESS_SIZE-1:0]           busAddress,
    input  logic                              busWriteEnable,
    input  logic [BUS_MASK_WIDTH-1:0]         busWriteMask,
    input  logic [BUS_DATA_WIDTH-1:0]         busDataWrite,
    output logic [BUS_DATA_WIDTH-1:0]         busDataRead,
    output logic                              busReady,
    output logic                              busError,
    output logic [$clog2(RAM_SIZE_WORDS)-1:0] ramAddress,
    output logic [BUS_DATA_WIDTH-1:0]         ramDataWrite,
    output logic [BUS_MASK_WIDTH-1:0]         ramWriteMask,
    output logic                              ramWriteEnable,
    output logic                              ramReadEnable,
    input  logic [BUS_DATA_WIDTH-1:0]         ramDataRead
);

    localparam int         RAM_ADDR_WIDTH = $clog2(RAM_SIZE_WORDS);
    localparam bit         HAS_WAIT       = WAIT_STATES > 0;
    localparam logic [3:0] WAIT_LAST      = 4'(WAIT_STATES - 1);

    state_t     state;
    state_t     next_state;
    request_t   req_q;
    request_t   req_d;
    logic [3:0] wait_q;
    logic [3:0] wait_d;
    logic       reject;

    // Request latches only load in IDLE, so they stay frozen for the whole transaction.
    always_comb begin
        req_d = req_q;
        if (state == IDLE && busValid) begin
            req_d.address = REQ_ADDR_WIDTH'(busAddress);
            req_d.data    = busDataWrite;
            req_d.mask    = busWriteMask;
            req_d.write   = busWriteEnable;
        end
    end

    memory_bus_range_check #(
        .RAM_SIZE_WORDS(RAM_SIZE_WORDS),
        .ROM_SIZE_WORDS(ROM_SIZE_WORDS)
    ) u_range_check (
        .address(req_d.address),
        .write  (req_d.write),
        .reject (reject)
    );

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        next_state = state;
        wait_d     = wait_q;
        unique case (state)
            IDLE: begin
                if (busValid) next_state = reject ? RESPOND : ACCESS;
            end
            ACCESS: begin
                if (req_q.write) next_state = HAS_WAIT ? WAIT : RESPOND;
                else             next_state = CAPTURE;
            end
            CAPTURE: next_state = HAS_WAIT ? WAIT : RESPOND;
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    next_state = RESPOND;
                    wait_d     = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wait_q <= '0;
            req_q  <= '0;
        end else begin
            state  <= next_state;
            wait_q <= wait_d;
            req_q  <= req_d;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ramReadEnable  <= 1'b0;
            ramWriteEnable <= 1'b0;
            ramAddress     <= '0;
            ramDataWrite   <= '0;
            ramWriteMask   <= '0;
            busReady       <= 1'b0;
            busError       <= 1'b0;
            busDataRead    <= '0;
        end else begin
            ramReadEnable  <= (next_state == ACCESS) && !req_d.write;
            ramWriteEnable <= (next_state == ACCESS) && req_d.write;
            if (next_state == ACCESS) begin
                ramAddress   <= req_d.address[RAM_ADDR_WIDTH-1:0];
                ramDataWrite <= req_d.data;
                ramWriteMask <= req_d.mask;
            end
            busReady <= (next_state == RESPOND);
            // A rejected request is the only path that goes straight from IDLE to RESPOND.
            busError <= (state == IDLE) && (next_state == RESPOND);
            if (state == CAPTURE) begin
                busDataRead <= ramDataRead;
            end else if (state == IDLE && next_state == RESPOND) begin
                busDataRead <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_sram_port.sv
// Scoreboard bench for memory_bus_sram_port: one instance with no wait states, one with three.
// Expectations follow MEMORY_BUS_WRITE_PROTECT_EN when it is defined.
module tb_memory_bus_sram_port;

    localparam int AW   = 15;
    localparam int RAW  = 11;
    localparam int WS_B = 3;
`ifdef MEMORY_BUS_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycle;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    logic           a_busValid,  b_busValid;
    logic [AW-1:0]  a_busAddress, b_busAddress;
    logic           a_busWriteEnable, b_busWriteEnable;
    logic [3:0]     a_busWriteMask, b_busWriteMask;
    logic [31:0]    a_busDataWrite, b_busDataWrite;
    logic [31:0]    a_busDataRead, b_busDataRead;
    logic           a_busReady, b_busReady;
    logic           a_busError, b_busError;
    logic [RAW-1:0] a_ramAddress, b_ramAddress;
    logic [31:0]    a_ramDataWrite, b_ramDataWrite;
    logic [3:0]     a_ramWriteMask, b_ramWriteMask;
    logic           a_ramWriteEnable, b_ramWriteEnable;
    logic           a_ramReadEnable, b_ramReadEnable;
    logic [31:0]    a_ramDataRead = '0, b_ramDataRead = '0;

    logic [31:0] mem_a [2048];
    logic [31:0] mem_b [2048];
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [31:0] last_a = '0, last_b = '0;
    int a_rd_cnt = 0, a_wr_cnt = 0, b_rd_cnt = 0, b_wr_cnt = 0, b_rd_cyc = -1;

    memory_bus_sram_port #(.WAIT_STATES(0)) dut_a (
        .clock(clock), .reset(reset),
        .busValid(a_busValid), .busAddress(a_busAddress), .busWriteEnable(a_busWriteEnable),
        .busWriteMask(a_busWriteMask), .busDataWrite(a_busDataWrite), .busDataRead(a_busDataRead),
        .busReady(a_busReady), .busError(a_busError), .ramAddress(a_ramAddress),
        .ramDataWrite(a_ramDataWrite), .ramWriteMask(a_ramWriteMask),
        .ramWriteEnable(a_ramWriteEnable), .ramReadEnable(a_ramReadEnable),
        .ramDataRead(a_ramDataRead)
    );

    memory_bus_sram_port #(.WAIT_STATES(WS_B)) dut_b (
        .clock(clock), .reset(reset),
        .busValid(b_busValid), .busAddress(b_busAddress), .busWriteEnable(b_busWriteEnable),
        .busWriteMask(b_busWriteMask), .busDataWrite(b_busDataWrite), .busDataRead(b_busDataRead),
        .busReady(b_busReady), .busError(b_busError), .ramAddress(b_ramAddress),
        .ramDataWrite(b_ramDataWrite), .ramWriteMask(b_ramWriteMask),
        .ramWriteEnable(b_ramWriteEnable), .ramReadEnable(b_ramReadEnable),
        .ramDataRead(b_ramDataRead)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Block RAM models with byte lanes and one-cycle read latency.
    always @(posedge clock) begin
        if (a_ramWriteEnable) begin
            for (int i = 0; i < 4; i++)
                if (a_ramWriteMask[i]) mem_a[a_ramAddress][8*i +: 8] <= a_ramDataWrite[8*i +: 8];
            a_wr_cnt <= a_wr_cnt + 1;
        end
        if (a_ramReadEnable) begin
            a_ramDataRead <= mem_a[a_ramAddress];
            a_rd_cnt      <= a_rd_cnt + 1;
        end
        if (b_ramWriteEnable) begin
            for (int i = 0; i < 4; i++)
                if (b_ramWriteMask[i]) mem_b[b_ramAddress][8*i +: 8] <= b_ramDataWrite[8*i +: 8];
            b_wr_cnt <= b_wr_cnt + 1;
        end
        if (b_ramReadEnable) begin
            b_ramDataRead <= mem_b[b_ramAddress];
            b_rd_cnt      <= b_rd_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitors: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (a_busReady === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_spurious_ready", 32'(a_busReady), 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_ready_cycle", cyc, ea.cycle);
                check("a_rdata", a_busDataRead, ea.data);
                check("a_error", 32'(a_busError), 32'(ea.err));
            end
        end
        if (b_busReady === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_spurious_ready", 32'(b_busReady), 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_ready_cycle", cyc, eb.cycle);
                check("b_rdata", b_busDataRead, eb.data);
                check("b_error", 32'(b_busError), 32'(eb.err));
            end
        end
        if (b_ramReadEnable === 1'b1) b_rd_cyc = cyc;
    end

    // Drives one request, pushes its expected response, holds it until ready.
    task automatic issue(input bit inst, input logic [AW-1:0] addr, input bit we,
                         input logic [3:0] mask, input logic [31:0] data, input bit err,
                         input logic [31:0] rd_exp, output int drive_cyc);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clock);
        drive_cyc = cyc;
        lat       = err ? 1 : ((we ? 2 : 3) + (inst ? WS_B : 0));
        e.cycle   = cyc + lat;
        e.err     = err;
        if (inst) begin
            e.data = err ? 32'd0 : (we ? last_b : rd_exp);
            last_b = e.data;
            qb.push_back(e);
            b_busAddress = addr; b_busWriteEnable = we; b_busWriteMask = mask;
            b_busDataWrite = data; b_busValid = 1'b1;
        end else begin
            e.data = err ? 32'd0 : (we ? last_a : rd_exp);
            last_a = e.data;
            qa.push_back(e);
            a_busAddress = addr; a_busWriteEnable = we; a_busWriteMask = mask;
            a_busDataWrite = data; a_busValid = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = inst ? b_busReady : a_busReady;
        end
        check(inst ? "b_ready_seen" : "a_ready_seen", 32'(seen), 32'd1);
        a_busValid = 1'b0;
        b_busValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dc, rd0, wr0, rdy_cnt;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 32'hB000_0000 | 32'(i);
        end
        a_busValid = 0; a_busAddress = '0; a_busWriteEnable = 0; a_busWriteMask = '0; a_busDataWrite = '0;
        b_busValid = 0; b_busAddress = '0; b_busWriteEnable = 0; b_busWriteMask = '0; b_busDataWrite = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_a_ready", 32'(a_busReady), 32'd0);
        check("rst_a_error", 32'(a_busError), 32'd0);
        check("rst_a_rdata", a_busDataRead, 32'd0);
        check("rst_a_strobes", {30'd0, a_ramReadEnable, a_ramWriteEnable}, 32'd0);
        check("rst_a_ramaddr", 32'(a_ramAddress), 32'd0);
        check("rst_b_ready", 32'(b_busReady), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Full write then read back, then single-lane merge.
        issue(0, 15'h010, 1, 4'hF, 32'hDEADBEEF, 0, '0, dc);
        issue(0, 15'h010, 0, 4'h0, '0, 0, 32'hDEADBEEF, dc);
        issue(0, 15'h010, 1, 4'h1, 32'h000000AA, 0, '0, dc);
        issue(0, 15'h010, 0, 4'h0, '0, 0, 32'hDEADBEAA, dc);

        // First out-of-range address: error response, no RAM strobe.
        rd0 = a_rd_cnt; wr0 = a_wr_cnt;
        issue(0, 15'h800, 0, 4'h0, '0, 1, '0, dc);
        check("a_err_rd_strobes", a_rd_cnt - rd0, 32'd0);
        check("a_err_wr_strobes", a_wr_cnt - wr0, 32'd0);

        // Zero mask still strobes but leaves the word untouched.
        wr0 = a_wr_cnt;
        issue(0, 15'h010, 1, 4'h0, 32'hFFFFFFFF, 0, '0, dc);
        check("a_mask0_wr_strobes", a_wr_cnt - wr0, 32'd1);
        issue(0, 15'h010, 0, 4'h0, '0, 0, 32'hDEADBEAA, dc);

        // Last in-range word and the top of the bus address space.
        issue(0, 15'h7FF, 1, 4'hF, 32'h13572468, 0, '0, dc);
        issue(0, 15'h7FF, 0, 4'h0, '0, 0, 32'h13572468, dc);
        wr0 = a_wr_cnt;
        issue(0, 15'h7FFF, 1, 4'hF, 32'hFFFFFFFF, 1, '0, dc);
        check("a_top_err_wr_strobes", a_wr_cnt - wr0, 32'd0);

        // Write-protect boundary.
        wr0 = a_wr_cnt;
        issue(0, 15'h0FF, 1, 4'hF, 32'h12345678, WP, '0, dc);
        check("a_rom_wr_strobes", a_wr_cnt - wr0, WP ? 32'd0 : 32'd1);
        issue(0, 15'h0FF, 0, 4'h0, '0, 0, WP ? 32'd0 : 32'h12345678, dc);
        issue(0, 15'h100, 1, 4'hF, 32'h55AA55AA, 0, '0, dc);
        issue(0, 15'h100, 0, 4'h0, '0, 0, 32'h55AA55AA, dc);

        // Three wait states.
        rd0 = b_rd_cnt;
        issue(1, 15'h020, 0, 4'h0, '0, 0, 32'hB0000020, dc);
        check("b_rd_strobes", b_rd_cnt - rd0, 32'd1);
        check("b_rd_strobe_cycle", b_rd_cyc, dc + 1);
        @(negedge clock);
        check("b_ready_one_cycle", 32'(b_busReady), 32'd0);
        issue(1, 15'h021, 1, 4'hF, 32'h0BADF00D, 0, '0, dc);
        issue(1, 15'h021, 0, 4'h0, '0, 0, 32'h0BADF00D, dc);

        // Reset while a read sits in CAPTURE.
        @(negedge clock);
        a_busAddress = 15'h010; a_busWriteEnable = 1'b0; a_busValid = 1'b1;
        @(negedge clock);
        check("a_pre_rst_strobe", 32'(a_ramReadEnable), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_a_ready", 32'(a_busReady), 32'd0);
        check("mid_rst_a_rdata", a_busDataRead, 32'd0);
        check("mid_rst_a_strobes", {30'd0, a_ramReadEnable, a_ramWriteEnable}, 32'd0);
        check("mid_rst_a_ramaddr", 32'(a_ramAddress), 32'd0);
        check("mid_rst_a_mask", 32'(a_ramWriteMask), 32'd0);
        check("mid_rst_b_rdata", b_busDataRead, 32'd0);
        a_busValid = 1'b0;
        last_a = '0;
        last_b = '0;
        @(negedge clock);
        reset = 1'b1;
        rdy_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (a_busReady === 1'b1) rdy_cnt++;
        end
        check("post_rst_no_ready", rdy_cnt, 32'd0);
        issue(0, 15'h010, 0, 4'h0, '0, 0, 32'hDEADBEAA, dc);

        repeat (3) @(negedge clock);
        check("a_queue_drained", qa.size(), 32'd0);
        check("b_queue_drained", qb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
